// File: rtl/fruit_tmpl_match.sv
// fruit_tmpl_match: streaming sum-of-absolute-differences template matcher.
// Feature samples arrive over a valid/ready handshake. Template samples come
// from an external synchronous ROM addressed by the sample index. After
// N_SAMPLES samples, the score is compared against a threshold latched at start.
// Optional feature: define TMPL_EARLY_ABORT_EN to stop a match as soon as
// the running sum exceeds the threshold.
module fruit_tmpl_match #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 8,
   parameter int N_SAMPLES  = 2048,
   parameter int ACC_WIDTH  = 19
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ACC_WIDTH-1:0]  thr,
   input  logic                  feat_valid,
   input  logic [DATA_WIDTH-1:0] feat_data,
   output logic                  feat_ready,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  busy,
   output logic                  score_valid,
   output logic [ACC_WIDTH-1:0]  score,
   output logic                  match,
   output logic                  aborted
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_SAMPLES - 1);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] idx;
   logic [DATA_WIDTH-1:0] feat_reg;
   logic                  feat_reg_vld;
   logic [ACC_WIDTH-1:0]  acc;
   logic [ACC_WIDTH-1:0]  thr_q;
   logic [DATA_WIDTH-1:0] abs_diff;
   logic                  hs;
   logic                  accept_start;
   logic                  abort_now;

   assign accept_start = (state == IDLE) && start;
   assign hs           = feat_ready && feat_valid;
   // feat_reg lines up with rom_data because the ROM has one cycle of read latency.
   assign abs_diff     = (feat_reg >= rom_data) ? (feat_reg - rom_data) : (rom_data - feat_reg);

`ifdef TMPL_EARLY_ABORT_EN
   logic abort_flag;

   // The accumulator is already past the threshold, so no more samples can
   // change the verdict.
   assign abort_now = ((state == RUN) || (state == DRAIN)) && (acc > thr_q);

   // Remember that an abort occurred, so it can be reported with the result.
   always_ff @(posedge clk) begin
      if (!rst_n)            abort_flag <= 1'b0;
      else if (accept_start) abort_flag <= 1'b0;
      else if (abort_now)    abort_flag <= 1'b1;
   end

   assign aborted = score_valid && abort_flag;
`else
   assign abort_now = 1'b0;
   assign aborted   = 1'b0;
`endif

   // Next state and handshake readiness; an abort preempts sample acceptance.
   always_comb begin
      state_nxt  = state;
      feat_ready = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = RUN;
         RUN: begin
            if (abort_now) state_nxt = DONE;
            else begin
               feat_ready = 1'b1;
               if (feat_valid && (idx == LAST_IDX)) state_nxt = DRAIN;
            end
         end
         DRAIN: state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, index, and sample pipeline. The accumulator freezes on an abort,
   // so the reported score is the value that crossed the threshold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         feat_reg     <= '0;
         feat_reg_vld <= 1'b0;
         acc          <= '0;
         thr_q        <= '0;
      end else begin
         state        <= state_nxt;
         feat_reg_vld <= hs;
         if (hs) begin
            feat_reg <= feat_data;
            idx      <= idx + 1'b1;
         end
         if (accept_start) begin
            acc   <= '0;
            idx   <= '0;
            thr_q <= thr;
         end else if (feat_reg_vld && !abort_now) begin
            acc <= acc + ACC_WIDTH'(abs_diff);
         end
      end
   end

   assign rom_addr    = idx;
   assign busy        = (state != IDLE);
   assign score_valid = (state == DONE);
   // The accumulator is cleared only by an accepted start, so it also serves as the held score.
   assign score       = acc;
   assign match       = score_valid && (acc <= thr_q);

endmodule
